// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end: instruction width,
// the bubble encoding and the fetch sequencer states.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port: request/grant handshake plus a response channel.
// The fetch stage is the master; the memory is the slave.
interface fetch_stage_if;
    import mips_pkg::*;

    logic               imem_req;
    logic [31:0]        imem_addr;
    logic               imem_gnt;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched instruction and its PC+4.
// Clear beats load, load beats unload, so load+unload replaces the entry.
module fetch_skid_buf
    import mips_pkg::*;
(
    input  logic               CLK,
    input  logic               reset_n,
    input  logic               load,
    input  logic               unload,
    input  logic               clear,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [31:0]        load_pc4,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        pc4,
    output logic               full
);
    logic               full_reg, full_next;
    logic [INSTR_W-1:0] instr_reg;
    logic [31:0]        pc4_reg;

    always_comb begin
        full_next = full_reg;
        if (clear)       full_next = 1'b0;
        else if (load)   full_next = 1'b1;
        else if (unload) full_next = 1'b0;
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            full_reg  <= 1'b0;
            instr_reg <= NOP_INSTR;
            pc4_reg   <= 32'h0;
        end else begin
            full_reg <= full_next;
            if (load && !clear) begin
                instr_reg <= load_instr;
                pc4_reg   <= load_pc4;
            end
        end
    end

    assign instr = instr_reg;
    assign pc4   = pc4_reg;
    assign full  = full_reg;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, keeps at most one fetch outstanding and loads IF/ID.
// A branch redirect flushes IF/ID and the skid entry and discards any stale response.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               CLK,
    input  logic               reset_n,
    input  logic               StallF,
    input  logic               StallD,
    input  logic               PCsrcD,
    input  logic [31:0]        pcBranchD,
    fetch_stage_if.master      imem,
    output logic [INSTR_W-1:0] instructionD,
    output logic [31:0]        pcplus4D,
    output logic               validD
);
    fetch_state_t       state_reg, state_next;
    logic [31:0]        pc_reg, pc_next;
    logic [31:0]        pc_req_reg, pc_req_next;
    logic [INSTR_W-1:0] ifid_instr_reg, ifid_instr_next;
    logic [31:0]        ifid_pc4_reg, ifid_pc4_next;
    logic               ifid_valid_reg, ifid_valid_next;
    logic               req, grant, resp_ok;
    logic               skid_load, skid_unload, skid_full;
    logic [INSTR_W-1:0] skid_instr;
    logic [31:0]        skid_pc4, resp_pc4;

    assign resp_pc4 = pc_req_reg + 32'd4;

    // Sequencer: a new request may go out in the same cycle the previous response lands
    always_comb begin
        state_next = state_reg;
        req        = 1'b0;
        resp_ok    = 1'b0;
        if (state_reg == ST_REQ || (state_reg == ST_WAIT && imem.imem_rvalid))
            req = ~StallF & ~PCsrcD & ~skid_full;
        grant = req & imem.imem_gnt;
        if (state_reg == ST_WAIT && imem.imem_rvalid && !PCsrcD)
            resp_ok = 1'b1;
        unique case (state_reg)
            ST_IDLE: state_next = ST_REQ;
            ST_REQ:  if (grant) state_next = ST_WAIT;
            ST_WAIT: begin
                if (grant)                  state_next = ST_WAIT;
                else if (imem.imem_rvalid)  state_next = ST_REQ;
                else if (PCsrcD)            state_next = ST_DROP;
            end
            ST_DROP: if (imem.imem_rvalid) state_next = ST_REQ;
        endcase
    end

    always_comb begin
        pc_next         = pc_reg;
        pc_req_next     = pc_req_reg;
        ifid_instr_next = ifid_instr_reg;
        ifid_pc4_next   = ifid_pc4_reg;
        ifid_valid_next = ifid_valid_reg;
        skid_unload     = skid_full & ~StallD;
        skid_load       = resp_ok & (StallD | skid_full);

        if (PCsrcD) begin
            pc_next = pcBranchD & 32'hFFFF_FFFC;
        end else if (grant) begin
            pc_next     = pc_reg + 32'd4;
            pc_req_next = pc_reg;
        end

        // Buffered instruction is older than any response arriving now
        if (PCsrcD) begin
            ifid_instr_next = NOP_INSTR;
            ifid_pc4_next   = 32'h0;
            ifid_valid_next = 1'b0;
        end else if (skid_unload) begin
            ifid_instr_next = skid_instr;
            ifid_pc4_next   = skid_pc4;
            ifid_valid_next = 1'b1;
        end else if (resp_ok && !StallD) begin
            ifid_instr_next = imem.imem_rdata;
            ifid_pc4_next   = resp_pc4;
            ifid_valid_next = 1'b1;
        end else if (!StallD) begin
            ifid_instr_next = NOP_INSTR;
            ifid_pc4_next   = 32'h0;
            ifid_valid_next = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            pc_reg         <= RESET_PC;
            pc_req_reg     <= RESET_PC;
            ifid_instr_reg <= NOP_INSTR;
            ifid_pc4_reg   <= 32'h0;
            ifid_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            pc_req_reg     <= pc_req_next;
            ifid_instr_reg <= ifid_instr_next;
            ifid_pc4_reg   <= ifid_pc4_next;
            ifid_valid_reg <= ifid_valid_next;
        end
    end

    fetch_skid_buf u_skid (
        .CLK        (CLK),
        .reset_n    (reset_n),
        .load       (skid_load),
        .unload     (skid_unload),
        .clear      (PCsrcD),
        .load_instr (imem.imem_rdata),
        .load_pc4   (resp_pc4),
        .instr      (skid_instr),
        .pc4        (skid_pc4),
        .full       (skid_full)
    );

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_reg;
    assign instructionD   = ifid_instr_reg;
    assign pcplus4D       = ifid_pc4_reg;
    assign validD         = ifid_valid_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a latency-configurable memory returning its address
// as data, a transaction-level reference model, and directed scenarios.
module tb_fetch_stage;
    import mips_pkg::*;

    logic        CLK = 1'b0;
    logic        reset_n, StallF, StallD, PCsrcD;
    logic [31:0] pcBranchD, instructionD, pcplus4D;
    logic        validD;

    fetch_stage_if imem ();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .CLK          (CLK),
        .reset_n      (reset_n),
        .StallF       (StallF),
        .StallD       (StallD),
        .PCsrcD       (PCsrcD),
        .pcBranchD    (pcBranchD),
        .imem         (imem),
        .instructionD (instructionD),
        .pcplus4D     (pcplus4D),
        .validD       (validD)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        int          rem;
    } mem_t;

    int   checks = 0;
    int   errors = 0;
    mem_t mem_q[$];
    int   lat = 1;
    bit   gnt_en = 1'b1;
    bit   inject_stale = 1'b0;
    logic seen_req;
    logic [31:0] seen_addr;

    // Reference model: fetch bookkeeping in terms of outstanding/stale requests
    bit          m_started, m_out, m_stale, m_valid;
    logic [31:0] m_pc, m_out_addr, m_instr, m_pc4;
    logic [31:0] sk_i[$], sk_p[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_out = 0; m_stale = 0; m_valid = 0;
        m_pc = 32'h0; m_out_addr = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
        sk_i.delete(); sk_p.delete();
    endtask

    task automatic cyc();
        logic        rv, exp_req, g, resp, acc;
        logic [31:0] rd;
        rv = 1'b0; rd = 32'h0;
        if (inject_stale) begin
            rv = 1'b1; rd = 32'hDEAD_BEEF; inject_stale = 1'b0;
        end else if (mem_q.size() > 0 && mem_q[0].rem == 0) begin
            rv = 1'b1; rd = mem_q[0].addr; void'(mem_q.pop_front());
        end
        imem.imem_rvalid = rv;
        imem.imem_rdata  = rd;
        imem.imem_gnt    = gnt_en;
        #2;
        exp_req = reset_n && m_started && !StallF && !PCsrcD && sk_i.size() == 0 &&
                  (!m_out || (!m_stale && rv));
        check("imem_req", {31'b0, imem.imem_req}, {31'b0, exp_req});
        check("imem_addr", imem.imem_addr, m_pc);
        seen_req  = imem.imem_req;
        seen_addr = imem.imem_addr;
        if (imem.imem_req && imem.imem_gnt) mem_q.push_back('{addr: imem.imem_addr, rem: lat});
        g = exp_req && gnt_en;
        @(posedge CLK);
        #1;
        foreach (mem_q[i]) if (mem_q[i].rem > 0) mem_q[i].rem = mem_q[i].rem - 1;
        if (!reset_n) begin
            model_reset();
        end else begin
            resp = m_out && rv;
            acc  = resp && !m_stale && !PCsrcD;
            if (PCsrcD) begin
                m_instr = 0; m_pc4 = 0; m_valid = 0;
                sk_i.delete(); sk_p.delete();
            end else if (sk_i.size() > 0 && !StallD) begin
                m_instr = sk_i.pop_front(); m_pc4 = sk_p.pop_front(); m_valid = 1;
                if (acc) begin sk_i.push_back(rd); sk_p.push_back(m_out_addr + 4); end
            end else if (acc) begin
                if (StallD) begin
                    sk_i.push_back(rd); sk_p.push_back(m_out_addr + 4);
                end else begin
                    m_instr = rd; m_pc4 = m_out_addr + 4; m_valid = 1;
                end
            end else if (!StallD) begin
                m_instr = 0; m_pc4 = 0; m_valid = 0;
            end
            if (resp) begin
                m_out = 0; m_stale = 0;
            end else if (PCsrcD && m_out) begin
                m_stale = 1;
            end
            if (g) begin
                m_out = 1; m_stale = 0; m_out_addr = m_pc; m_pc = m_pc + 4;
            end
            if (PCsrcD) m_pc = pcBranchD & 32'hFFFF_FFFC;
            m_started = 1;
        end
        check("instructionD", instructionD, m_instr);
        check("pcplus4D", pcplus4D, m_pc4);
        check("validD", {31'b0, validD}, {31'b0, m_valid});
        if (validD) $display("IFID instr=%h pc4=%h", instructionD, pcplus4D);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        reset_n = 0; StallF = 0; StallD = 0; PCsrcD = 0; pcBranchD = 32'h0;
        imem.imem_gnt = 0; imem.imem_rvalid = 0; imem.imem_rdata = 32'h0;
        model_reset();
        #1;
        check("rst_req", {31'b0, imem.imem_req}, 32'd0);
        check("rst_valid", {31'b0, validD}, 32'd0);
        @(posedge CLK);
        #1;
        cyc(); cyc();
        reset_n = 1;

        // Zero-wait streaming from RESET_PC
        cyc();
        cyc();
        check("first_req", {31'b0, seen_req}, 32'd1);
        check("first_addr", seen_addr, 32'h0);
        cyc();
        check("s0_instr", instructionD, 32'h0);
        check("s0_pc4", pcplus4D, 32'h4);
        check("s0_valid", {31'b0, validD}, 32'd1);
        cyc();
        check("s1_instr", instructionD, 32'h4);
        check("s1_pc4", pcplus4D, 32'h8);
        cyc();
        check("s2_pc4", pcplus4D, 32'hC);

        // Decode stall for three cycles
        StallF = 1; StallD = 1;
        repeat (3) cyc();
        check("stall_instr", instructionD, 32'h8);
        check("stall_pc4", pcplus4D, 32'hC);
        check("stall_req", {31'b0, seen_req}, 32'd0);
        StallF = 0; StallD = 0;
        cyc();
        check("unload_instr", instructionD, 32'hC);
        check("unload_pc4", pcplus4D, 32'h10);
        cyc();
        cyc();
        check("after_stall_pc4", pcplus4D, 32'h14);
        repeat (2) cyc();

        // Redirect while a 3-cycle fetch is outstanding
        lat = 3;
        cyc();
        PCsrcD = 1; pcBranchD = 32'h0000_0103;
        cyc();
        PCsrcD = 0;
        check("redir_valid", {31'b0, validD}, 32'd0);
        check("redir_pc", imem.imem_addr, 32'h100);
        got = 0;
        for (int i = 0; i < 20 && validD !== 1'b1; i++) begin
            cyc();
            if (seen_req && !got) begin
                check("redir_addr", seen_addr, 32'h100);
                got = 1;
            end
        end
        check("redir_instr", instructionD, 32'h100);
        check("redir_pc4", pcplus4D, 32'h104);

        // Redirect in the same cycle a response arrives
        lat = 1;
        repeat (5) cyc();
        PCsrcD = 1; pcBranchD = 32'h200;
        cyc();
        PCsrcD = 0;
        check("same_req", {31'b0, seen_req}, 32'd0);
        check("same_valid", {31'b0, validD}, 32'd0);
        check("same_pc", imem.imem_addr, 32'h200);
        cyc();
        check("same_next_req", {31'b0, seen_req}, 32'd1);
        check("same_next_addr", seen_addr, 32'h200);
        cyc();
        check("same_pc4", pcplus4D, 32'h204);

        // Grant withheld, then fetch stall
        gnt_en = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("nogrant_req", {31'b0, seen_req}, 32'd1);
        end
        check("nogrant_addr", imem.imem_addr, 32'h208);
        gnt_en = 1; StallF = 1;
        repeat (2) cyc();
        check("stallf_req", {31'b0, seen_req}, 32'd0);
        check("stallf_addr", imem.imem_addr, 32'h208);
        StallF = 0;
        cyc();
        cyc();
        check("resume_instr", instructionD, 32'h208);
        check("resume_pc4", pcplus4D, 32'h20C);

        // Asynchronous reset while waiting on a slow response
        lat = 3;
        cyc();
        cyc();
        #1;
        reset_n = 0;
        #1;
        check("arst_req", {31'b0, imem.imem_req}, 32'd0);
        check("arst_instr", instructionD, 32'h0);
        check("arst_pc4", pcplus4D, 32'h0);
        check("arst_valid", {31'b0, validD}, 32'd0);
        check("arst_addr", imem.imem_addr, 32'h0);
        model_reset();
        mem_q.delete();
        lat = 1;
        cyc(); cyc();
        reset_n = 1;
        inject_stale = 1;
        cyc();
        for (int i = 0; i < 10 && validD !== 1'b1; i++) cyc();
        check("restart_instr", instructionD, 32'h0);
        check("restart_pc4", pcplus4D, 32'h4);
        check("restart_valid", {31'b0, validD}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
